// File: rtl/id_ex_operand_stage_if.sv
// ID/EX operand-stage bus: D-side instruction/operand inputs, E-stage control,
// and the registered E-side operand outputs.
interface id_ex_operand_stage_if #(
  parameter int DATA_W = 32
);
  logic [31:0]       instrD;
  logic              validD;
  logic [DATA_W-1:0] rd2D;
  logic              stallE;
  logic              flushE;
  logic [DATA_W-1:0] BE;
  logic [DATA_W-1:0] signimmE;
  logic [DATA_W-1:0] zeroimmE;
  logic [DATA_W-1:0] upperimmR;
  logic [1:0]        alusrcE;
  logic              validE;
  logic              illegalE;

  modport master (
    output instrD, validD, rd2D, stallE, flushE,
    input  BE, signimmE, zeroimmE, upperimmR, alusrcE, validE, illegalE
  );

  modport slave (
    input  instrD, validD, rd2D, stallE, flushE,
    output BE, signimmE, zeroimmE, upperimmR, alusrcE, validE, illegalE
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX stage producing every B-side ALU operand: decodes the ALU source select,
// forms sign/zero/upper immediates and registers them with rt into E.
module id_ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  id_ex_operand_stage_if.slave bus
);

  logic [5:0]        w_op;
  logic [IMM_W-1:0]  w_imm;
  logic [1:0]        w_alusrc;
  logic              w_legal;
  logic              w_illegal;
  logic [DATA_W-1:0] w_sign;
  logic [DATA_W-1:0] w_zero;
  logic [DATA_W-1:0] w_upper;
  logic              w_unused;

  logic [DATA_W-1:0] r_be;
  logic [DATA_W-1:0] r_sign;
  logic [DATA_W-1:0] r_zero;
  logic [DATA_W-1:0] r_upper;
  logic [1:0]        r_alusrc;
  logic              r_valid;
  logic              r_illegal;

  assign w_op     = bus.instrD[31:26];
  assign w_imm    = bus.instrD[IMM_W-1:0];
  assign w_unused = ^bus.instrD[25:IMM_W];

  assign w_sign  = {{(DATA_W-IMM_W){w_imm[IMM_W-1]}}, w_imm};
  assign w_zero  = {{(DATA_W-IMM_W){1'b0}}, w_imm};
  assign w_upper = {w_imm, {(DATA_W-IMM_W){1'b0}}};

  always_comb begin
    w_alusrc = 2'd0;
    w_legal  = 1'b1;
    case (w_op)
      6'h00, 6'h04, 6'h05:                      w_alusrc = 2'd0;
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B: w_alusrc = 2'd1;
      6'h0C, 6'h0D, 6'h0E:                      w_alusrc = 2'd2;
      6'h0F:                                    w_alusrc = 2'd3;
      default:                                  w_legal  = 1'b0;
    endcase
  end

  // An empty slot never reports an illegal opcode.
  assign w_illegal = bus.validD & ~w_legal;

  // Reset and flush both yield the all-zero bubble; flush beats a concurrent stall.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.flushE) begin
      r_be      <= '0;
      r_sign    <= '0;
      r_zero    <= '0;
      r_upper   <= '0;
      r_alusrc  <= '0;
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
    end else if (!bus.stallE) begin
      r_be      <= bus.rd2D;
      r_sign    <= w_sign;
      r_zero    <= w_zero;
      r_upper   <= w_upper;
      r_alusrc  <= w_alusrc;
      r_valid   <= bus.validD;
      r_illegal <= w_illegal;
    end
  end

  assign bus.BE        = r_be;
  assign bus.signimmE  = r_sign;
  assign bus.zeroimmE  = r_zero;
  assign bus.upperimmR = r_upper;
  assign bus.alusrcE   = r_alusrc;
  assign bus.validE    = r_valid;
  assign bus.illegalE  = r_illegal;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed scenarios followed by random traffic,
// all compared against a table-driven reference model of the E-stage outputs.
module tb_id_ex_operand_stage;

  logic clk;
  logic rst_n;

  id_ex_operand_stage_if #(.DATA_W(32)) bus_if ();

  id_ex_operand_stage #(.DATA_W(32), .IMM_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks;
  int unsigned n_err;

  // Opcode table: legal opcodes and the operand source each one selects.
  logic [5:0] legal_op  [0:12] = '{6'h00, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
                                   6'h23, 6'h2B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
  logic [1:0] legal_src [0:12] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1,
                                   2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3};

  logic [31:0] m_be, m_sign, m_zero, m_upper;
  logic [1:0]  m_src;
  logic        m_valid, m_ill;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [31:0] imm;
    logic [1:0]  src;
    bit          found;
    if (!rst_n || bus_if.flushE) begin
      m_be = 0; m_sign = 0; m_zero = 0; m_upper = 0; m_src = 0; m_valid = 0; m_ill = 0;
    end else if (!bus_if.stallE) begin
      imm   = {16'h0, bus_if.instrD[15:0]};
      src   = 2'd0;
      found = 0;
      for (int i = 0; i < 13; i++)
        if (legal_op[i] == bus_if.instrD[31:26]) begin
          src   = legal_src[i];
          found = 1;
        end
      m_be    = bus_if.rd2D;
      m_zero  = imm;
      m_sign  = (imm >= 32'h8000) ? imm + 32'hFFFF_0000 : imm;
      m_upper = imm * 32'd65536;
      m_src   = src;
      m_valid = bus_if.validD;
      m_ill   = bus_if.validD && !found;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".BE"},        bus_if.BE,                m_be);
    chk({tag, ".signimmE"},  bus_if.signimmE,          m_sign);
    chk({tag, ".zeroimmE"},  bus_if.zeroimmE,          m_zero);
    chk({tag, ".upperimmR"}, bus_if.upperimmR,         m_upper);
    chk({tag, ".alusrcE"},   {30'd0, bus_if.alusrcE},  {30'd0, m_src});
    chk({tag, ".validE"},    {31'd0, bus_if.validE},   {31'd0, m_valid});
    chk({tag, ".illegalE"},  {31'd0, bus_if.illegalE}, {31'd0, m_ill});
  endtask

  task automatic drive(input logic [31:0] instr, input logic valid, input logic [31:0] rd2,
                       input logic stall, input logic flush, input logic rstn);
    bus_if.instrD = instr;
    bus_if.validD = valid;
    bus_if.rd2D   = rd2;
    bus_if.stallE = stall;
    bus_if.flushE = flush;
    rst_n         = rstn;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [31:0] instr;
    n_checks = 0;
    n_err    = 0;
    m_be = 0; m_sign = 0; m_zero = 0; m_upper = 0; m_src = 0; m_valid = 0; m_ill = 0;

    // Reset, then release with the same addi -1
    drive(32'h2008_FFFF, 1'b1, 32'h1111_2222, 1'b0, 1'b0, 1'b0);
    tick("reset");
    chk("reset_sign", bus_if.signimmE, 32'h0);
    chk("reset_valid", {31'd0, bus_if.validE}, 32'd0);
    rst_n = 1'b1;
    tick("release");
    chk("rel_sign",  bus_if.signimmE,  32'hFFFF_FFFF);
    chk("rel_zero",  bus_if.zeroimmE,  32'h0000_FFFF);
    chk("rel_upper", bus_if.upperimmR, 32'hFFFF_0000);
    chk("rel_src",   {30'd0, bus_if.alusrcE}, 32'd1);
    chk("rel_valid", {31'd0, bus_if.validE},  32'd1);

    // Decode sweep
    drive(32'h3508_8001, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
    tick("ori");
    chk("ori_src",  {30'd0, bus_if.alusrcE}, 32'd2);
    chk("ori_zero", bus_if.zeroimmE, 32'h0000_8001);
    drive(32'h3C08_1234, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
    tick("lui");
    chk("lui_src",   {30'd0, bus_if.alusrcE}, 32'd3);
    chk("lui_upper", bus_if.upperimmR, 32'h1234_0000);
    drive(32'h0109_5020, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
    tick("rtype");
    chk("rtype_src", {30'd0, bus_if.alusrcE}, 32'd0);
    chk("rtype_be",  bus_if.BE, 32'hDEAD_BEEF);

    // Stall for three edges, then release
    drive(32'h2008_0005, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
    tick("addi");
    drive(32'h3508_8001, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick("stall");
      chk("stall_src",  {30'd0, bus_if.alusrcE}, 32'd1);
      chk("stall_sign", bus_if.signimmE, 32'd5);
    end
    bus_if.stallE = 1'b0;
    tick("unstall");
    chk("unstall_src",  {30'd0, bus_if.alusrcE}, 32'd2);
    chk("unstall_zero", bus_if.zeroimmE, 32'h0000_8001);

    // Flush beats stall, then a clean load
    drive(32'h3C08_ABCD, 1'b1, 32'h5555_AAAA, 1'b1, 1'b1, 1'b1);
    tick("flush");
    chk("flush_valid", {31'd0, bus_if.validE}, 32'd0);
    chk("flush_upper", bus_if.upperimmR, 32'h0);
    drive(32'h3C08_ABCD, 1'b1, 32'h5555_AAAA, 1'b0, 1'b0, 1'b1);
    tick("postflush");
    chk("postflush_upper", bus_if.upperimmR, 32'hABCD_0000);

    // Illegal opcode, valid and invalid
    drive(32'hFC00_ABCD, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
    tick("illegal");
    chk("illegal_flag", {31'd0, bus_if.illegalE}, 32'd1);
    chk("illegal_src",  {30'd0, bus_if.alusrcE}, 32'd0);
    drive(32'hFC00_ABCD, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick("invalid");
    chk("invalid_flag", {31'd0, bus_if.illegalE}, 32'd0);
    chk("invalid_zero", bus_if.zeroimmE, 32'h0000_ABCD);

    // Reset during a stall, stall keeps holding zeros
    drive(32'h2008_0777, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b1);
    tick("prestall");
    rst_n = 1'b0;
    tick("rst_in_stall");
    chk("rst_in_stall_zero", bus_if.zeroimmE, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick("stall_after_rst");
      chk("hold_zero_valid", {31'd0, bus_if.validE}, 32'd0);
      chk("hold_zero_be",    bus_if.BE, 32'h0);
    end

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      instr = $urandom;
      if ($urandom_range(3) != 0)
        instr[31:26] = legal_op[$urandom_range(12)];
      drive(instr, ($urandom_range(99) < 85), $urandom,
            ($urandom_range(99) < 20), ($urandom_range(99) < 10),
            ($urandom_range(99) >= 3));
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
